// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin AR/R arbiter and router for two masters, two slaves and a DECERR default slave
module axi_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ADDR_W-1:0] ARADDR_M0,
  input  logic [ADDR_W-1:0] ARADDR_M1,
  input  logic              ARVALID_M0,
  input  logic              ARVALID_M1,
  input  logic [LEN_W-1:0]  ARLEN_M0,
  input  logic [LEN_W-1:0]  ARLEN_M1,
  input  logic              ARREADY_S0,
  input  logic              ARREADY_S1,
  input  logic              RVALID_S0,
  input  logic              RVALID_S1,
  input  logic              RLAST_S0,
  input  logic              RLAST_S1,
  input  logic              RREADY_M0,
  input  logic              RREADY_M1,
  output logic [1:0]        AR_master_sel,
  output logic [2:0]        AR_slave_sel,
  output logic [1:0]        R_master_sel,
  output logic [2:0]        R_slave_sel,
  output logic              DEF_ARREADY,
  output logic              DEF_RVALID,
  output logic              DEF_RLAST,
  output logic [1:0]        DEF_RRESP
);
  typedef enum logic [1:0] {IDLE, AR, R, R_DEF} state_t;
  state_t state;
  logic gnt, last_grant, pick, arvalid_g, rready_g, arready_t, rvalid_t, rlast_t, unused_ok;
  logic [2:0] slv, dec0, dec1;
  logic [LEN_W-1:0] len, cnt;
  logic [1:0] msel;
  assign dec0 = ARADDR_M0[ADDR_W-1:16] == '0 ? 3'b001 : ARADDR_M0[ADDR_W-1:16] == 1 ? 3'b010 : 3'b100;
  assign dec1 = ARADDR_M1[ADDR_W-1:16] == '0 ? 3'b001 : ARADDR_M1[ADDR_W-1:16] == 1 ? 3'b010 : 3'b100;
  assign unused_ok = ^{ARADDR_M0[15:0], ARADDR_M1[15:0]};
  // on a tie the master that did not win last time gets the grant
  assign pick      = ARVALID_M0 && ARVALID_M1 ? ~last_grant : ARVALID_M1;
  assign arvalid_g = gnt ? ARVALID_M1 : ARVALID_M0;
  assign rready_g  = gnt ? RREADY_M1 : RREADY_M0;
  assign arready_t = slv[0] ? ARREADY_S0 : slv[1] ? ARREADY_S1 : 1'b1;
  assign rvalid_t  = slv[0] ? RVALID_S0 : RVALID_S1;
  assign rlast_t   = slv[0] ? RLAST_S0 : RLAST_S1;
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      slv        <= '0;
      len        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (ARVALID_M0 || ARVALID_M1) begin
          gnt        <= pick;
          last_grant <= pick;
          slv        <= pick ? dec1 : dec0;
          len        <= pick ? ARLEN_M1 : ARLEN_M0;
          state      <= AR;
        end
        AR: if (arvalid_g && arready_t) begin
          cnt   <= '0;
          state <= slv[2] ? R_DEF : R;
        end
        R: if (rvalid_t && rready_g && rlast_t) state <= IDLE;
        default: if (rready_g) begin
          cnt <= cnt + 1'b1;
          if (cnt == len) state <= IDLE;
        end
      endcase
    end
  end
  assign msel          = {gnt, ~gnt};
  assign AR_master_sel = state == AR ? msel : '0;
  assign AR_slave_sel  = state == AR ? slv : '0;
  assign R_master_sel  = state == R || state == R_DEF ? msel : '0;
  assign R_slave_sel   = state == R ? slv : state == R_DEF ? 3'b100 : '0;
  assign DEF_ARREADY   = state == AR && slv[2];
  assign DEF_RVALID    = state == R_DEF;
  assign DEF_RLAST     = state == R_DEF && cnt == len;
  assign DEF_RRESP     = 2'b11;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed table, hand sequences and random traffic against a transaction-level model
module tb_axi_read_arbiter;
  logic ACLK = 1'b0, ARESETn = 1'b1;
  logic [31:0] addr0, addr1;
  logic [3:0] l0, l1;
  logic v0, v1, ars0, ars1, rv0, rv1, rl0, rl1, rr0, rr1;
  logic [1:0] arm, rm, resp;
  logic [2:0] asl, rs;
  logic dar, drv, drl;
  logic [14:0] got;
  int vecs = 0, errs = 0;
  int m_phase, m_mst, m_tgt, m_left, m_last;

  axi_read_arbiter #(.ADDR_W(32), .LEN_W(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARADDR_M0(addr0), .ARADDR_M1(addr1), .ARVALID_M0(v0), .ARVALID_M1(v1),
    .ARLEN_M0(l0), .ARLEN_M1(l1), .ARREADY_S0(ars0), .ARREADY_S1(ars1),
    .RVALID_S0(rv0), .RVALID_S1(rv1), .RLAST_S0(rl0), .RLAST_S1(rl1),
    .RREADY_M0(rr0), .RREADY_M1(rr1),
    .AR_master_sel(arm), .AR_slave_sel(asl), .R_master_sel(rm), .R_slave_sel(rs),
    .DEF_ARREADY(dar), .DEF_RVALID(drv), .DEF_RLAST(drl), .DEF_RRESP(resp)
  );

  always #5 ACLK = ~ACLK;
  assign got = {arm, asl, rm, rs, dar, drv, drl, resp};

  function automatic logic [14:0] mk(logic [1:0] a_m, logic [2:0] a_s, logic [1:0] r_m,
                                     logic [2:0] r_s, logic da, logic dv, logic dl);
    return {a_m, a_s, r_m, r_s, da, dv, dl, 2'b11};
  endfunction

  task automatic check(string name, logic [14:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // reference model: phase 0 idle, 1 address, 2 data; m_left counts beats still owed
  function automatic int decode(logic [31:0] a);
    return a[31:16] == 16'h0000 ? 0 : a[31:16] == 16'h0001 ? 1 : 2;
  endfunction

  function automatic logic [14:0] m_exp();
    logic [1:0] mm;
    logic [2:0] ts;
    mm = 2'(1 << m_mst);
    ts = 3'(1 << m_tgt);
    return mk(m_phase == 1 ? mm : '0, m_phase == 1 ? ts : '0, m_phase == 2 ? mm : '0,
              m_phase == 2 ? ts : '0, m_phase == 1 && m_tgt == 2, m_phase == 2 && m_tgt == 2,
              m_phase == 2 && m_tgt == 2 && m_left == 1);
  endfunction

  task automatic m_step();
    logic rdy, rr;
    case (m_phase)
      0: if (v0 || v1) begin
        m_mst   = (v0 && v1) ? 1 - m_last : (v1 ? 1 : 0);
        m_last  = m_mst;
        m_tgt   = decode(m_mst == 1 ? addr1 : addr0);
        m_left  = int'(m_mst == 1 ? l1 : l0) + 1;
        m_phase = 1;
      end
      1: begin
        rdy = m_tgt == 0 ? ars0 : m_tgt == 1 ? ars1 : 1'b1;
        if ((m_mst == 1 ? v1 : v0) && rdy) m_phase = 2;
      end
      default: begin
        rr = m_mst == 1 ? rr1 : rr0;
        if (m_tgt == 2) begin
          if (rr) begin
            m_left--;
            if (m_left == 0) m_phase = 0;
          end
        end else if ((m_tgt == 1 ? rv1 : rv0) && rr && (m_tgt == 1 ? rl1 : rl0)) m_phase = 0;
      end
    endcase
  endtask

  task automatic clear();
    {v0, v1, ars0, ars1, rv0, rv1, rl0, rl1, rr0, rr1} = '0;
    addr0 = '0; addr1 = '0; l0 = '0; l1 = '0;
  endtask

  task automatic cyc(string name);
    m_step();
    @(posedge ACLK);
    #1;
    check({name, "/model"}, m_exp());
  endtask

  // outputs must drop before any clock edge arrives
  task automatic do_reset(string name);
    #1 ARESETn = 1'b0;
    clear();
    m_phase = 0; m_last = 1; m_mst = 0; m_tgt = 0; m_left = 0;
    #1 check(name, mk('0, '0, '0, '0, 1'b0, 1'b0, 1'b0));
    @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  typedef struct {
    logic [1:0] arv;
    logic [31:0] a0, a1;
    logic [3:0] ln0, ln1;
    logic [1:0] ardy, rvl, rlst, rrdy;
    logic [14:0] exp;
  } vec_t;
  vec_t tbl[19];

  initial begin
    logic [14:0] idle_o, ar_s0, r_s0, ar_s1, r_s1, ar_d, rd, rd_last;
    idle_o  = mk('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    ar_s0   = mk(2'b01, 3'b001, '0, '0, 1'b0, 1'b0, 1'b0);
    r_s0    = mk('0, '0, 2'b01, 3'b001, 1'b0, 1'b0, 1'b0);
    ar_s1   = mk(2'b10, 3'b010, '0, '0, 1'b0, 1'b0, 1'b0);
    r_s1    = mk('0, '0, 2'b10, 3'b010, 1'b0, 1'b0, 1'b0);
    ar_d    = mk(2'b10, 3'b100, '0, '0, 1'b1, 1'b0, 1'b0);
    rd      = mk('0, '0, 2'b10, 3'b100, 1'b0, 1'b1, 1'b0);
    rd_last = mk('0, '0, 2'b10, 3'b100, 1'b0, 1'b1, 1'b1);
    // M0 -> S0, ARLEN 0, ARREADY after two cycles
    tbl[0]  = '{2'b01, 32'h40, 32'h0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b00, ar_s0};
    tbl[1]  = '{2'b01, 32'h40, 32'h0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b00, ar_s0};
    tbl[2]  = '{2'b01, 32'h40, 32'h0, 4'd0, 4'd0, 2'b01, 2'b00, 2'b00, 2'b00, r_s0};
    tbl[3]  = '{2'b00, 32'h40, 32'h0, 4'd0, 4'd0, 2'b00, 2'b01, 2'b01, 2'b01, idle_o};
    // M1 -> S1, ARLEN 3, RREADY stalls on beat 2
    tbl[4]  = '{2'b10, 32'h0, 32'h10000, 4'd0, 4'd3, 2'b00, 2'b00, 2'b00, 2'b00, ar_s1};
    tbl[5]  = '{2'b10, 32'h0, 32'h10000, 4'd0, 4'd3, 2'b10, 2'b00, 2'b00, 2'b00, r_s1};
    tbl[6]  = '{2'b00, 32'h0, 32'h10000, 4'd0, 4'd3, 2'b00, 2'b10, 2'b00, 2'b10, r_s1};
    tbl[7]  = '{2'b00, 32'h0, 32'h10000, 4'd0, 4'd3, 2'b00, 2'b10, 2'b00, 2'b00, r_s1};
    tbl[8]  = '{2'b00, 32'h0, 32'h10000, 4'd0, 4'd3, 2'b00, 2'b10, 2'b10, 2'b00, r_s1};
    tbl[9]  = '{2'b00, 32'h0, 32'h10000, 4'd0, 4'd3, 2'b00, 2'b10, 2'b00, 2'b10, r_s1};
    tbl[10] = '{2'b00, 32'h0, 32'h10000, 4'd0, 4'd3, 2'b00, 2'b10, 2'b00, 2'b10, r_s1};
    tbl[11] = '{2'b00, 32'h0, 32'h10000, 4'd0, 4'd3, 2'b00, 2'b10, 2'b10, 2'b10, idle_o};
    // M1 -> default slave, ARLEN 2, with stalls
    tbl[12] = '{2'b10, 32'h0, 32'h20000, 4'd0, 4'd2, 2'b00, 2'b00, 2'b00, 2'b00, ar_d};
    tbl[13] = '{2'b10, 32'h0, 32'h20000, 4'd0, 4'd2, 2'b00, 2'b00, 2'b00, 2'b00, rd};
    tbl[14] = '{2'b00, 32'h0, 32'h20000, 4'd0, 4'd2, 2'b00, 2'b00, 2'b00, 2'b10, rd};
    tbl[15] = '{2'b00, 32'h0, 32'h20000, 4'd0, 4'd2, 2'b00, 2'b00, 2'b00, 2'b00, rd};
    tbl[16] = '{2'b00, 32'h0, 32'h20000, 4'd0, 4'd2, 2'b00, 2'b00, 2'b00, 2'b10, rd_last};
    tbl[17] = '{2'b00, 32'h0, 32'h20000, 4'd0, 4'd2, 2'b00, 2'b00, 2'b00, 2'b00, rd_last};
    tbl[18] = '{2'b00, 32'h0, 32'h20000, 4'd0, 4'd2, 2'b00, 2'b00, 2'b00, 2'b10, idle_o};

    clear();
    do_reset("reset_state");
    for (int i = 0; i < 19; i++) begin
      {v1, v0} = tbl[i].arv; addr0 = tbl[i].a0; addr1 = tbl[i].a1;
      l0 = tbl[i].ln0; l1 = tbl[i].ln1; {ars1, ars0} = tbl[i].ardy;
      {rv1, rv0} = tbl[i].rvl; {rl1, rl0} = tbl[i].rlst; {rr1, rr0} = tbl[i].rrdy;
      cyc($sformatf("vec%0d", i));
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // simultaneous requests straight after reset, then alternation
    do_reset("reset2");
    v0 = 1; v1 = 1; addr0 = 32'h40; addr1 = 32'h0001_0000;
    cyc("tie"); check("tie_m0_first", ar_s0);
    ars0 = 1; cyc("tie"); ars0 = 0; check("tie_m0_r", r_s0);
    rv0 = 1; rl0 = 1; rr0 = 1; cyc("tie"); rv0 = 0; rl0 = 0; rr0 = 0; check("tie_m0_done", idle_o);
    cyc("tie"); check("tie_m1_second", ar_s1);
    ars1 = 1; cyc("tie"); ars1 = 0; check("m1_r", r_s1);
    cyc("tie"); check("m0_blocked", r_s1);
    rv1 = 1; rl1 = 1; rr1 = 1; cyc("tie"); rv1 = 0; rl1 = 0; rr1 = 0; check("m1_done", idle_o);
    cyc("tie"); check("alt_m0", ar_s0);
    ars0 = 1; cyc("tie"); ars0 = 0; v0 = 0; v1 = 0;
    rv0 = 1; rl0 = 1; rr0 = 1; cyc("tie"); rv0 = 0; rl0 = 0; rr0 = 0; check("alt_m0_done", idle_o);

    // reset in the middle of an S1 burst
    v1 = 1; addr1 = 32'h0001_0000; l1 = 4'd3;
    cyc("mid"); check("mid_ar", ar_s1);
    ars1 = 1; cyc("mid"); ars1 = 0; v1 = 0; check("mid_r", r_s1);
    rv1 = 1; rr1 = 1; cyc("mid"); check("mid_beat", r_s1);
    do_reset("mid_async_reset");
    v1 = 1; addr1 = 32'h0001_0000;
    cyc("post"); check("post_m1", ar_s1);
    ars1 = 1; cyc("post"); ars1 = 0;
    rv1 = 1; rl1 = 1; rr1 = 1; cyc("post"); rv1 = 0; rl1 = 0; rr1 = 0; check("post_done", idle_o);
    v0 = 1; addr0 = 32'h40;
    cyc("post"); check("post_tie_m0", ar_s0);

    // random traffic against the model
    do_reset("reset3");
    for (int n = 0; n < 4000; n++) begin
      int p;
      if ($urandom_range(0, 399) == 0) do_reset("rand_reset");
      v0 = $urandom_range(0, 9) < 6; v1 = $urandom_range(0, 9) < 6;
      p = $urandom_range(0, 3);
      addr0 = {p == 3 ? 16'hbeef : 16'(p), 16'($urandom)};
      p = $urandom_range(0, 3);
      addr1 = {p == 3 ? 16'h8001 : 16'(p), 16'($urandom)};
      l0 = 4'($urandom_range(0, 3)); l1 = 4'($urandom_range(0, 3));
      ars0 = $urandom_range(0, 2) == 0; ars1 = $urandom_range(0, 2) == 0;
      rv0 = $urandom_range(0, 1) == 0; rv1 = $urandom_range(0, 1) == 0;
      rl0 = $urandom_range(0, 3) == 0; rl1 = $urandom_range(0, 3) == 0;
      rr0 = $urandom_range(0, 9) < 7; rr1 = $urandom_range(0, 9) < 7;
      cyc("rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
